// File: rtl/micro_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : micro_sequencer
// Purpose  : Microcode sequencer. Accepts a macro opcode from fetch, dispatches
//            to its micro-routine entry {opcode, 3'b000}, steps a micro-PC
//            through a synchronous control-store ROM and presents each
//            micro-instruction to micro_inst_decoder. Resolves micro-branches
//            from the micro-instruction type field [43:41] and returns to
//            dispatch on END.
// Ports    : clk, rst_n (async, active-low)
//            instr_valid/instr_opcode/instr_ready : macro opcode handshake
//            rom_addr -> / rom_data <-            : control-store access
//            branch_cond, stall                   : execution controls
//            minstr_out/minstr_valid/upc          : to micro_inst_decoder
//            seq_fault                            : sticky sequencing fault
// Config   : UCPU_SEQ_TRAP_EN - when defined, micro-PC overflow and reserved
//            types 3'b101/3'b110 trap into a sticky FAULT state. When
//            undefined, seq_fault is tied low and the micro-PC wraps.
// Revision : 1.0 - initial release
// ============================================================================
module micro_sequencer #(
    parameter int MINST_WIDTH  = 44,
    parameter int UPC_WIDTH    = 8,
    parameter int OPCODE_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   instr_valid,
    input  logic [OPCODE_WIDTH-1:0] instr_opcode,
    output logic                   instr_ready,
    output logic [UPC_WIDTH-1:0]   rom_addr,
    input  logic [MINST_WIDTH-1:0] rom_data,
    input  logic                   branch_cond,
    input  logic                   stall,
    output logic [MINST_WIDTH-1:0] minstr_out,
    output logic                   minstr_valid,
    output logic [UPC_WIDTH-1:0]   upc,
    output logic                   seq_fault
);

    // State encoding
    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_ADDR  = 3'd1;
    localparam logic [2:0] c_ST_DATA  = 3'd2;
    localparam logic [2:0] c_ST_EXEC  = 3'd3;
`ifdef UCPU_SEQ_TRAP_EN
    localparam logic [2:0] c_ST_FAULT = 3'd4;
`endif

    // Micro-instruction type field values
    localparam logic [2:0] c_TYPE_END  = 3'b111;
    localparam logic [2:0] c_TYPE_BR   = 3'b100;
    localparam logic [2:0] c_TYPE_CBR  = 3'b011;
`ifdef UCPU_SEQ_TRAP_EN
    localparam logic [2:0] c_TYPE_RSV5 = 3'b101;
    localparam logic [2:0] c_TYPE_RSV6 = 3'b110;
`endif

    localparam int c_TGT_LSB = 10;

    logic [2:0]             r_state;
    logic [UPC_WIDTH-1:0]   r_upc;
    logic [UPC_WIDTH-1:0]   r_rom_addr;
    logic [MINST_WIDTH-1:0] r_minstr;

    logic [2:0]             w_state_nxt;
    logic [UPC_WIDTH-1:0]   w_upc_nxt;
    logic                   w_upc_load;
    logic                   w_minstr_load;

    logic [2:0]             w_type;
    logic [UPC_WIDTH-1:0]   w_target;
    logic [UPC_WIDTH-1:0]   w_seq;
    logic                   w_taken;

    assign w_type   = r_minstr[MINST_WIDTH-1 -: 3];
    assign w_target = r_minstr[c_TGT_LSB +: UPC_WIDTH];
    assign w_seq    = r_upc + 1'b1;
    // A not-taken conditional branch counts as a sequential step.
    assign w_taken  = (w_type == c_TYPE_BR) ||
                      ((w_type == c_TYPE_CBR) && branch_cond);

`ifdef UCPU_SEQ_TRAP_EN
    logic w_trap;
    assign w_trap = (w_type == c_TYPE_RSV5) || (w_type == c_TYPE_RSV6) ||
                    (!w_taken && (r_upc == {UPC_WIDTH{1'b1}}));
`endif

    // Next-state and register-load decode
    always_comb begin
        w_state_nxt   = r_state;
        w_upc_nxt     = r_upc;
        w_upc_load    = 1'b0;
        w_minstr_load = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (instr_valid) begin
                    w_upc_nxt   = {instr_opcode, {(UPC_WIDTH-OPCODE_WIDTH){1'b0}}};
                    w_upc_load  = 1'b1;
                    w_state_nxt = c_ST_ADDR;
                end
            end
            // ROM samples rom_addr on the edge leaving ADDR.
            c_ST_ADDR: w_state_nxt = c_ST_DATA;
            c_ST_DATA: begin
                w_minstr_load = 1'b1;
                w_state_nxt   = c_ST_EXEC;
            end
            c_ST_EXEC: begin
                if (!stall) begin
                    if (w_type == c_TYPE_END) begin
                        w_state_nxt = c_ST_IDLE;
                    end
`ifdef UCPU_SEQ_TRAP_EN
                    else if (w_trap) begin
                        w_state_nxt = c_ST_FAULT;
                    end
`endif
                    else begin
                        w_upc_nxt   = w_taken ? w_target : w_seq;
                        w_upc_load  = 1'b1;
                        w_state_nxt = c_ST_ADDR;
                    end
                end
            end
`ifdef UCPU_SEQ_TRAP_EN
            // Only reset leaves FAULT.
            c_ST_FAULT: w_state_nxt = c_ST_FAULT;
`endif
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_ST_IDLE;
            r_upc      <= '0;
            r_rom_addr <= '0;
            r_minstr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_upc_load) begin
                r_upc      <= w_upc_nxt;
                r_rom_addr <= w_upc_nxt;
            end
            if (w_minstr_load) begin
                r_minstr <= rom_data;
            end
        end
    end

    assign instr_ready  = (r_state == c_ST_IDLE);
    assign minstr_valid = (r_state == c_ST_EXEC);
    assign rom_addr     = r_rom_addr;
    assign upc          = r_upc;
    assign minstr_out   = r_minstr;
`ifdef UCPU_SEQ_TRAP_EN
    assign seq_fault    = (r_state == c_ST_FAULT);
`else
    assign seq_fault    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_micro_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_micro_sequencer
// Purpose  : Self-checking bench for micro_sequencer. A synchronous ROM model
//            feeds the DUT; a transaction-level reference model (busy flag,
//            fetch-latency countdown, integer micro-PC) predicts every output
//            and is compared each cycle. Directed scenarios pin the model with
//            literal expectations, then randomized stimulus runs against it.
//            Honours UCPU_SEQ_TRAP_EN the same way as the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_micro_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic [4:0]  instr_opcode = '0;
    logic        instr_ready;
    logic [7:0]  rom_addr;
    logic [43:0] rom_data = '0;
    logic        branch_cond = 1'b0;
    logic        stall = 1'b0;
    logic [43:0] minstr_out;
    logic        minstr_valid;
    logic [7:0]  upc;
    logic        seq_fault;

    logic [43:0] rom [0:255];

    int n_cmp = 0;
    int n_err = 0;

    micro_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_valid  (instr_valid),
        .instr_opcode (instr_opcode),
        .instr_ready  (instr_ready),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .branch_cond  (branch_cond),
        .stall        (stall),
        .minstr_out   (minstr_out),
        .minstr_valid (minstr_valid),
        .upc          (upc),
        .seq_fault    (seq_fault)
    );

    always #5 clk = ~clk;

    // Synchronous control store: data appears the cycle after address capture.
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_busy  = 1'b0;
    bit          m_fault = 1'b0;
    int          m_wait  = 0;      // fetch cycles left before the word is live
    int          m_pc    = 0;
    logic [43:0] m_word  = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_fault = 0; m_wait = 0; m_pc = 0; m_word = '0;
        end else if (m_fault) begin
            // stuck until reset
        end else if (!m_busy) begin
            if (instr_valid) begin
                m_pc = int'(instr_opcode) * 8;
                m_busy = 1; m_wait = 2;
            end
        end else if (m_wait != 0) begin
            m_wait--;
            if (m_wait == 0) m_word = rom[m_pc];
        end else if (!stall) begin
            int  t, tgt;
            bit  taken;
            t   = int'(m_word[43:41]);
            tgt = int'(m_word[17:10]);
            if (t == 7) begin
                m_busy = 0;
            end else begin
                taken = (t == 4) || (t == 3 && branch_cond);
`ifdef UCPU_SEQ_TRAP_EN
                if (t == 5 || t == 6 || (!taken && m_pc == 255)) m_fault = 1;
                else begin
                    m_pc = taken ? tgt : (m_pc + 1) % 256;
                    m_wait = 2;
                end
`else
                m_pc = taken ? tgt : (m_pc + 1) % 256;
                m_wait = 2;
`endif
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        chk("cyc_ready", 64'(instr_ready),  64'(!m_busy && !m_fault));
        chk("cyc_valid", 64'(minstr_valid), 64'(m_busy && m_wait == 0 && !m_fault));
        chk("cyc_upc",   64'(upc),          64'(m_pc));
        chk("cyc_raddr", 64'(rom_addr),     64'(m_pc));
        chk("cyc_minst", 64'(minstr_out),   64'(m_word));
        chk("cyc_fault", 64'(seq_fault),    64'(m_fault));
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [43:0] mk(input logic [2:0] t, input logic [7:0] tgt);
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        r[43:41] = t;
        r[17:10] = tgt;
        return r[43:0];
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic accept(input logic [4:0] op);
        instr_valid = 1'b1;
        instr_opcode = op;
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!instr_ready && n < 200) begin @(negedge clk); n++; end
        chk(tag, 64'(instr_ready), 64'd1);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!minstr_valid && n < 20) begin @(negedge clk); n++; end
        chk(tag, 64'(minstr_valid), 64'd1);
    endtask

    task automatic rst_pulse();
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [43:0] w;
        for (int i = 0; i < 256; i++) rom[i] = mk(3'b111, 8'h00);

        // Reset state
        repeat (3) tick();
        chk("rst_ready", 64'(instr_ready), 64'd1);
        chk("rst_valid", 64'(minstr_valid), 64'd0);
        chk("rst_upc",   64'(upc), 64'd0);
        chk("rst_raddr", 64'(rom_addr), 64'd0);
        chk("rst_minst", 64'(minstr_out), 64'd0);
        chk("rst_fault", 64'(seq_fault), 64'd0);
        rst_n = 1'b1;
        tick();

        // Dispatch, sequential step, unconditional branch, END
        w = mk(3'b000, 8'h5A);
        rom[8'h18] = w;
        rom[8'h19] = mk(3'b100, 8'h40);
        rom[8'h40] = mk(3'b111, 8'h00);
        accept(5'd3);
        chk("disp_raddr", 64'(rom_addr), 64'h18);
        chk("disp_busy",  64'(instr_ready), 64'd0);
        tick();
        chk("lat_t1_valid", 64'(minstr_valid), 64'd0);
        tick();
        chk("lat_t2_valid", 64'(minstr_valid), 64'd1);
        chk("lat_t2_minst", 64'(minstr_out), 64'(w));
        tick();
        chk("seq_raddr", 64'(rom_addr), 64'h19);
        chk("gap_valid", 64'(minstr_valid), 64'd0);
        wait_valid("br_wait");
        tick();
        chk("br_raddr", 64'(rom_addr), 64'h40);
        wait_valid("end_wait");
        tick();
        chk("end_ready", 64'(instr_ready), 64'd1);

        // Conditional branch, taken and not taken (back-to-back dispatch)
        rom[8'h20] = mk(3'b000, 8'h11);
        rom[8'h21] = mk(3'b011, 8'h80);
        rom[8'h80] = mk(3'b111, 8'h00);
        rom[8'h22] = mk(3'b111, 8'h00);
        for (int k = 0; k < 2; k++) begin
            branch_cond = (k == 0);
            accept(5'd4);
            wait_valid("cbr_w0");
            tick();
            wait_valid("cbr_w1");
            chk("cbr_upc", 64'(upc), 64'h21);
            tick();
            chk(k == 0 ? "cbr_taken" : "cbr_fall", 64'(rom_addr), k == 0 ? 64'h80 : 64'h22);
            wait_idle("cbr_idle");
        end
        branch_cond = 1'b0;

        // Stall held for four cycles in EXEC
        w = mk(3'b000, 8'h33);
        rom[8'h28] = w;
        rom[8'h29] = mk(3'b111, 8'h00);
        accept(5'd5);
        wait_valid("stl_wait");
        stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("stl_valid", 64'(minstr_valid), 64'd1);
            chk("stl_upc",   64'(upc), 64'h28);
            chk("stl_minst", 64'(minstr_out), 64'(w));
        end
        stall = 1'b0;
        tick();
        chk("stl_rel_valid", 64'(minstr_valid), 64'd0);
        chk("stl_rel_upc",   64'(upc), 64'h29);
        wait_idle("stl_idle");

        // Async reset in DATA, opcode honoured on first edge after release
        rom[8'h30] = mk(3'b111, 8'h00);
        instr_valid = 1'b1;
        instr_opcode = 5'd3;
        tick();
        tick();
        instr_opcode = 5'd6;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(minstr_valid), 64'd0);
        chk("arst_upc",   64'(upc), 64'd0);
        chk("arst_ready", 64'(instr_ready), 64'd1);
        tick();
        rst_n = 1'b1;
        tick();
        chk("arst_accept", 64'(rom_addr), 64'h30);
        instr_valid = 1'b0;
        wait_idle("arst_idle");

        // Sequential step at micro-PC 0xFF
        rom[8'hF8] = mk(3'b100, 8'hFF);
        rom[8'hFF] = mk(3'b000, 8'h00);
        rom[8'h00] = mk(3'b111, 8'h00);
        accept(5'd31);
        wait_valid("ff_w0");
        tick();
        wait_valid("ff_w1");
        chk("ff_upc", 64'(upc), 64'hFF);
        tick();
`ifdef UCPU_SEQ_TRAP_EN
        chk("trap_fault", 64'(seq_fault), 64'd1);
        chk("trap_valid", 64'(minstr_valid), 64'd0);
        chk("trap_ready", 64'(instr_ready), 64'd0);
        repeat (3) tick();
        chk("trap_sticky", 64'(seq_fault), 64'd1);
        rst_pulse();
        tick();
        chk("trap_clear", 64'(seq_fault), 64'd0);
`else
        chk("wrap_raddr", 64'(rom_addr), 64'h00);
        chk("wrap_fault", 64'(seq_fault), 64'd0);
        wait_idle("wrap_idle");
`endif

        // Randomized run against the model
        for (int i = 0; i < 256; i++) begin
            logic [2:0] t;
            t = ($urandom_range(0, 3) == 0) ? 3'b111 : 3'($urandom_range(0, 7));
            rom[i] = mk(t, 8'($urandom()));
        end
        for (int c = 0; c < 5000; c++) begin
            tick();
            instr_valid  = 1'($urandom());
            instr_opcode = 5'($urandom());
            stall        = ($urandom_range(0, 3) == 0);
            branch_cond  = 1'($urandom());
            if ($urandom_range(0, 299) == 0 || (seq_fault && $urandom_range(0, 7) == 0))
                rst_pulse();
        end

        instr_valid = 1'b0;
        stall = 1'b0;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
